echo_detector: RTL and testbench
================================

Name: echo_detector

Overview:
- Sits between the receive beamformer and the time-of-flight stage; consumes the beamformed waveform sample stream.
- Learns a DC baseline during a post-burst blanking window, then thresholds the absolute deviation from that baseline.
- Requires a run of consecutive over-threshold samples before declaring an echo.
- Reports a sticky echo flag, a one-cycle echo pulse, the emission-relative timestamp of the first over-threshold sample of the confirming run, and a no-echo timeout.

Parameters:
- DATA_WIDTH, 16, width of sample_in and threshold_in.
- TIME_WIDTH, 24, width of time_since_emission_in and echo_time_out.
- AVG_LOG2, 4, log2 of the number of blanking-window samples averaged into the baseline.
- BLANK_CYCLES, 600000, minimum time_since_emission before arming (covers the burst and ringdown).
- CONFIRM_COUNT, 3, consecutive over-threshold valid samples required for detection (≥1).
- WINDOW_CYCLES, 16000000, time_since_emission at which an armed, undetected cycle times out.

Ports:
- clk_in, input, 1, system clock (100 MHz).
- rst_in, input, 1, reset, asynchronous, active-high.
- burst_start_in, input, 1, synchronous restart pulse at each new emission.
- sample_in, input, DATA_WIDTH, unsigned beamformed sample.
- sample_valid_in, input, 1, qualifies sample_in for one cycle.
- time_since_emission_in, input, TIME_WIDTH, free-running count since last burst_start.
- threshold_in, input, DATA_WIDTH, deviation threshold; sampled on every valid sample.
- echo_detected_out, output, 1, sticky until the next burst_start_in or reset.
- echo_pulse_out, output, 1, single-cycle detection strobe.
- echo_time_out, output, TIME_WIDTH, timestamp of the first sample in the confirming run.
- no_echo_out, output, 1, single-cycle timeout strobe.
- baseline_out, output, DATA_WIDTH, current baseline.
- peak_out, output, DATA_WIDTH, peak deviation (see Optional Feature).
- state_out, output, 3, encoded FSM state for debug.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all accumulators and counters 0.
- States:
  - IDLE: wait for burst_start_in.
  - BLANK: accumulate the sum of the first 2^AVG_LOG2 valid samples; sum register is DATA_WIDTH+AVG_LOG2 bits.
  - ARMED: look for over-threshold samples.
  - CONFIRM: count the over-threshold run.
  - DETECTED: echo latched.
  - TIMEOUT: no echo this cycle.
- burst_start_in in any state: clear the sum, the run counter, echo_detected_out, echo_time_out and peak_out; enter BLANK. It takes priority over a simultaneous sample_valid_in, and that sample is dropped.
- BLANK → ARMED: requires both conditions:
  - time_since_emission_in ≥ BLANK_CYCLES;
  - sample count reached 2^AVG_LOG2.
  - On transition, baseline_out ← sum >> AVG_LOG2 (truncating). Samples arriving after the average is full are ignored.
- Deviation: dev = |sample_in − baseline_out|, computed at DATA_WIDTH+1 bits signed; the result always fits DATA_WIDTH. Over-threshold means dev > threshold_in (strictly greater).
- ARMED, valid and over-threshold:
  - capture that sample's time_since_emission_in as the candidate time; run count = 1.
  - If CONFIRM_COUNT = 1, go directly to DETECTED; otherwise go to CONFIRM.
- CONFIRM:
  - Valid over-threshold sample: increment the run count; at CONFIRM_COUNT go to DETECTED.
  - Valid sample not over threshold: clear the run count and return to ARMED.
  - Cycles without a valid sample do not break the run.
- On entering DETECTED, in the cycle after the confirming sample:
  - echo_pulse_out = 1 for exactly one cycle;
  - echo_detected_out = 1 (sticky);
  - echo_time_out = candidate time.
  - DETECTED holds until burst_start_in.
- Timeout: time_since_emission_in ≥ WINDOW_CYCLES while in BLANK, ARMED or CONFIRM → TIMEOUT. no_echo_out pulses for one cycle; TIMEOUT holds until burst_start_in. A timeout in the same cycle as a confirming sample resolves to DETECTED.
- Latency: 1 cycle from the confirming valid sample to echo_pulse_out.
- Asynchronous reset mid-operation returns to IDLE immediately; the baseline is lost.

Optional Feature:
- Macro ECHO_PEAK_TRACK_EN.
- Defined: in DETECTED, peak_out ← max(peak_out, dev) on each valid sample. The first DETECTED value is the maximum dev seen across the confirming run.
- Undefined: peak_out is tied to 0 and no peak comparator is built.

Decomposition:
- Shared package echo_pkg holds:
  - state enum echo_state_t (IDLE, BLANK, ARMED, CONFIRM, DETECTED, TIMEOUT);
  - default parameter constants.
- One natural sub-module: baseline_averager (sample accumulator plus shift, with done flag).

Test Plan:
- BLANK_CYCLES=100, AVG_LOG2=2, baseline samples 500,502,498,500 → baseline_out=500 on arming, and no echo flagged during blanking even with sample 900.
- Armed, threshold 50, samples 560,570,580 at times 200,300,400 (CONFIRM_COUNT=3) → echo_pulse_out one cycle after the third sample; echo_time_out=200; echo_detected_out stays 1.
- Samples 560,510,560,570,580 → run breaks at 510; echo_time_out equals the time of the second 560.
- Sample exactly 550 with threshold 50 (dev=50) → not counted.
- No excursion until WINDOW_CYCLES → single no_echo_out pulse; state_out=TIMEOUT; echo_detected_out=0.
- burst_start_in coincident with a valid sample while in DETECTED → all flags cleared, state BLANK, sample ignored. Asynchronous rst_in mid-CONFIRM → all outputs 0 immediately.

Source files
------------

// File: rtl/echo_pkg.sv
// Shared types and default configuration for the echo detector.
package echo_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StBlank    = 3'd1,
    StArmed    = 3'd2,
    StConfirm  = 3'd3,
    StDetected = 3'd4,
    StTimeout  = 3'd5
  } echo_state_t;

  localparam int unsigned DefDataWidth    = 16;
  localparam int unsigned DefTimeWidth    = 24;
  localparam int unsigned DefAvgLog2      = 4;
  localparam int unsigned DefBlankCycles  = 600000;
  localparam int unsigned DefConfirmCount = 3;
  localparam int unsigned DefWindowCycles = 16000000;

endpackage

// File: rtl/baseline_averager.sv
// Sums the first 2^AVG_LOG2 accepted samples after a clear and presents their
// truncated mean; done stays high and further samples are ignored once full.
module baseline_averager
  import echo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned AVG_LOG2   = DefAvgLog2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  clear_in,
  input  logic                  accept_in,
  input  logic [DATA_WIDTH-1:0] sample_in,
  output logic                  done_out,
  output logic [DATA_WIDTH-1:0] average_out
);

  localparam int unsigned SumWidth = DATA_WIDTH + AVG_LOG2;
  localparam logic [AVG_LOG2:0] FullCount = (AVG_LOG2 + 1)'(2 ** AVG_LOG2);

  logic [SumWidth-1:0] sum_q;
  logic [AVG_LOG2:0]   count_q;

  assign done_out    = (count_q == FullCount);
  assign average_out = sum_q[SumWidth-1:AVG_LOG2];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sum_q   <= '0;
      count_q <= '0;
    end else if (clear_in) begin
      sum_q   <= '0;
      count_q <= '0;
    end else if (accept_in && !done_out) begin
      sum_q   <= sum_q + SumWidth'(sample_in);
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/echo_detector.sv
// Baseline-subtracting echo detector with run confirmation and no-echo timeout.
// Optional peak-deviation tracking is enabled by defining ECHO_PEAK_TRACK_EN.
module echo_detector
  import echo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DefDataWidth,
  parameter int unsigned TIME_WIDTH    = DefTimeWidth,
  parameter int unsigned AVG_LOG2      = DefAvgLog2,
  parameter int unsigned BLANK_CYCLES  = DefBlankCycles,
  parameter int unsigned CONFIRM_COUNT = DefConfirmCount,
  parameter int unsigned WINDOW_CYCLES = DefWindowCycles
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  burst_start_in,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid_in,
  input  logic [TIME_WIDTH-1:0] time_since_emission_in,
  input  logic [DATA_WIDTH-1:0] threshold_in,
  output logic                  echo_detected_out,
  output logic                  echo_pulse_out,
  output logic [TIME_WIDTH-1:0] echo_time_out,
  output logic                  no_echo_out,
  output logic [DATA_WIDTH-1:0] baseline_out,
  output logic [DATA_WIDTH-1:0] peak_out,
  output logic [2:0]            state_out
);

  localparam int unsigned RunWidth = $clog2(CONFIRM_COUNT + 1);
  localparam logic [RunWidth-1:0]   RunTarget  = RunWidth'(CONFIRM_COUNT);
  localparam logic [TIME_WIDTH-1:0] BlankTime  = TIME_WIDTH'(BLANK_CYCLES);
  localparam logic [TIME_WIDTH-1:0] WindowTime = TIME_WIDTH'(WINDOW_CYCLES);

  echo_state_t           state_q;
  logic [RunWidth-1:0]   run_cnt_q;
  logic [TIME_WIDTH-1:0] cand_time_q;

  logic                  avg_done;
  logic [DATA_WIDTH-1:0] avg_value;
  logic signed [DATA_WIDTH:0] diff;
  logic [DATA_WIDTH-1:0] dev;
  logic                  over_thr;
  logic                  run_done;
  logic                  confirm_hit;
  logic                  timed_out;

  baseline_averager #(
    .DATA_WIDTH (DATA_WIDTH),
    .AVG_LOG2   (AVG_LOG2)
  ) u_baseline_averager (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .clear_in    (burst_start_in),
    .accept_in   ((state_q == StBlank) && sample_valid_in),
    .sample_in   (sample_in),
    .done_out    (avg_done),
    .average_out (avg_value)
  );

  always_comb begin
    diff     = $signed({1'b0, sample_in}) - $signed({1'b0, baseline_out});
    dev      = DATA_WIDTH'(diff[DATA_WIDTH] ? -diff : diff);
    over_thr = sample_valid_in && (dev > threshold_in);
    run_done = ((run_cnt_q + 1'b1) == RunTarget);
    // The sample that completes the run; it beats a simultaneous timeout.
    confirm_hit = over_thr && (((state_q == StArmed) && (CONFIRM_COUNT == 1)) ||
                               ((state_q == StConfirm) && run_done));
    timed_out = (time_since_emission_in >= WindowTime) &&
                (state_q inside {StBlank, StArmed, StConfirm});
  end

  assign state_out = state_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q           <= StIdle;
      run_cnt_q         <= '0;
      cand_time_q       <= '0;
      echo_detected_out <= 1'b0;
      echo_pulse_out    <= 1'b0;
      echo_time_out     <= '0;
      no_echo_out       <= 1'b0;
      baseline_out      <= '0;
    end else begin
      echo_pulse_out <= 1'b0;
      no_echo_out    <= 1'b0;
      if (burst_start_in) begin
        state_q           <= StBlank;
        run_cnt_q         <= '0;
        echo_detected_out <= 1'b0;
        echo_time_out     <= '0;
      end else if (confirm_hit) begin
        state_q           <= StDetected;
        run_cnt_q         <= RunTarget;
        echo_detected_out <= 1'b1;
        echo_pulse_out    <= 1'b1;
        echo_time_out     <= (state_q == StArmed) ? time_since_emission_in : cand_time_q;
      end else if (timed_out) begin
        state_q     <= StTimeout;
        no_echo_out <= 1'b1;
      end else begin
        case (state_q)
          StBlank: begin
            if (avg_done && (time_since_emission_in >= BlankTime)) begin
              baseline_out <= avg_value;
              state_q      <= StArmed;
            end
          end
          StArmed: begin
            if (over_thr) begin
              cand_time_q <= time_since_emission_in;
              run_cnt_q   <= RunWidth'(1);
              state_q     <= StConfirm;
            end
          end
          StConfirm: begin
            if (over_thr) begin
              run_cnt_q <= run_cnt_q + 1'b1;
            end else if (sample_valid_in) begin
              run_cnt_q <= '0;
              state_q   <= StArmed;
            end
          end
          StIdle, StDetected, StTimeout: ;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

`ifdef ECHO_PEAK_TRACK_EN
  logic [DATA_WIDTH-1:0] run_peak_q;
  logic [DATA_WIDTH-1:0] peak_q;
  logic [DATA_WIDTH-1:0] run_max;

  // A run always restarts from ARMED, so only CONFIRM carries the prior maximum.
  assign run_max  = ((state_q == StConfirm) && (run_peak_q > dev)) ? run_peak_q : dev;
  assign peak_out = peak_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      run_peak_q <= '0;
      peak_q     <= '0;
    end else if (burst_start_in) begin
      run_peak_q <= '0;
      peak_q     <= '0;
    end else begin
      if (over_thr && (state_q inside {StArmed, StConfirm})) begin
        run_peak_q <= run_max;
      end
      if (confirm_hit) begin
        peak_q <= run_max;
      end else if ((state_q == StDetected) && sample_valid_in && (dev > peak_q)) begin
        peak_q <= dev;
      end
    end
  end
`else
  assign peak_out = '0;
`endif

endmodule

// File: tb/tb_echo_detector.sv
// Randomized scoreboard bench for echo_detector: an episode-level reference model
// predicts each detection or timeout, and a monitor checks every DUT event.
module tb_echo_detector;
  import echo_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned TW = 24;
  localparam int unsigned AL = 2;
  localparam int unsigned BC = 100;
  localparam int unsigned CC = 3;
  localparam int unsigned WC = 1500;

  logic          clk_100mhz = 1'b0;
  logic          rst = 1'b1;
  logic          burst = 1'b0;
  logic [DW-1:0] sample = '0;
  logic          valid = 1'b0;
  logic [TW-1:0] tse = '0;
  logic [DW-1:0] threshold = '0;
  logic          echo_detected, echo_pulse, no_echo;
  logic [TW-1:0] echo_time;
  logic [DW-1:0] baseline, peak;
  logic [2:0]    state;

  echo_detector #(
    .DATA_WIDTH    (DW),
    .TIME_WIDTH    (TW),
    .AVG_LOG2      (AL),
    .BLANK_CYCLES  (BC),
    .CONFIRM_COUNT (CC),
    .WINDOW_CYCLES (WC)
  ) dut (
    .clk_in                 (clk_100mhz),
    .rst_in                 (rst),
    .burst_start_in         (burst),
    .sample_in              (sample),
    .sample_valid_in        (valid),
    .time_since_emission_in (tse),
    .threshold_in           (threshold),
    .echo_detected_out      (echo_detected),
    .echo_pulse_out         (echo_pulse),
    .echo_time_out          (echo_time),
    .no_echo_out            (no_echo),
    .baseline_out           (baseline),
    .peak_out               (peak),
    .state_out              (state)
  );

  always #5 clk_100mhz = ~clk_100mhz;
  always @(posedge clk_100mhz) tse <= burst ? '0 : tse + 1'b1;

  typedef struct {
    bit          is_echo;
    int unsigned obs_time;
    int unsigned echo_time;
    int unsigned peak;
    int unsigned baseline;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned smp_val[int];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: baseline is the mean of the first 2^AL samples inside blanking; after
  // arming, the first run of CC strictly-over-threshold samples wins unless the
  // window expires first.
  function automatic exp_t model(input int unsigned thr);
    exp_t e;
    int unsigned n = 0, sum = 0, base, run = 0, cand = 0, pk = 0, dev, v;
    e.is_echo = 0; e.obs_time = WC + 1; e.echo_time = 0; e.peak = 0;
    for (int t = 0; t <= int'(WC); t++) begin
      if (smp_val.exists(t)) begin
        v = smp_val[t];
        if (t <= int'(BC)) begin
          if (n < (1 << AL)) begin sum += v; n++; end
        end else begin
          base = sum >> AL;
          dev  = (v > base) ? v - base : base - v;
          if (dev > thr) begin
            if (run == 0) begin cand = t; pk = 0; end
            run++;
            if (dev > pk) pk = dev;
            if (run == CC) begin
              e.is_echo = 1; e.obs_time = t + 1; e.echo_time = cand; e.peak = pk;
              break;
            end
          end else begin
            run = 0;
          end
        end
      end
    end
    e.baseline = sum >> AL;
    return e;
  endfunction

  always @(negedge clk_100mhz) begin
    if (!rst && (echo_pulse || no_echo)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {echo_pulse, no_echo}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("echo_pulse", echo_pulse, mon_e.is_echo);
        check("no_echo_pulse", no_echo, !mon_e.is_echo);
        check("event_time", tse, mon_e.obs_time);
        check("event_state", state, mon_e.is_echo ? StDetected : StTimeout);
        check("echo_detected", echo_detected, mon_e.is_echo);
        check("echo_time", echo_time, mon_e.echo_time);
        check("baseline", baseline, mon_e.baseline);
`ifdef ECHO_PEAK_TRACK_EN
        check("peak", peak, mon_e.peak);
`else
        check("peak", peak, 0);
`endif
      end
    end
  end

  task automatic load_blank();
    smp_val[10] = 500; smp_val[20] = 502; smp_val[30] = 498; smp_val[40] = 500;
    smp_val[50] = 900;
  endtask

  task automatic gen_random(output int unsigned thr);
    int unsigned nom, sum = 0, base, v, r, n;
    int t;
    nom = $urandom_range(1000, 60000);
    thr = $urandom_range(20, 300);
    t = $urandom_range(0, 5);
    for (int i = 0; i < 4; i++) begin
      v = nom - 3 + $urandom_range(0, 6);
      smp_val[t] = v; sum += v;
      t += $urandom_range(1, 15);
    end
    smp_val[t] = $urandom_range(0, 65535);
    base = sum >> AL;
    t = BC + 10 + $urandom_range(0, 20);
    n = $urandom_range(5, 40);
    for (int i = 0; i < int'(n); i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      v = base - 3 + $urandom_range(0, 6);
      else if (r < 6) v = $urandom_range(0, 1) ? base + thr : base - thr;
      else if ($urandom_range(0, 1)) v = base + thr + $urandom_range(1, 500);
      else            v = base - thr - $urandom_range(1, 500);
      smp_val[t] = v;
      t += $urandom_range(1, 25);
    end
  endtask

  task automatic run_episode(input int unsigned thr, input bit burst_sample,
                             input int unsigned rst_at);
    exp_t e;
    int unsigned end_t;
    e = model(thr);
    if (rst_at == 0) exp_q.push_back(e);
    end_t = (rst_at != 0) ? rst_at : e.obs_time + 3;
    @(negedge clk_100mhz);
    burst = 1'b1; threshold = DW'(thr); valid = burst_sample; sample = DW'($urandom);
    @(negedge clk_100mhz);
    burst = 1'b0;
    check("burst_detected_clr", echo_detected, 0);
    check("burst_time_clr", echo_time, 0);
    check("burst_state", state, StBlank);
    check("burst_peak_clr", peak, 0);
    for (int unsigned t = 0; t <= end_t; t++) begin
      if (t != 0) @(negedge clk_100mhz);
      if (rst_at != 0 && t == rst_at) begin
        valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_state", state, StIdle);
        check("arst_detected", echo_detected, 0);
        check("arst_pulses", {echo_pulse, no_echo}, 0);
        check("arst_time", echo_time, 0);
        check("arst_baseline", baseline, 0);
        check("arst_peak", peak, 0);
        @(negedge clk_100mhz);
        rst = 1'b0;
        smp_val.delete();
        return;
      end
      valid  = smp_val.exists(int'(t));
      sample = valid ? DW'(smp_val[int'(t)]) : DW'($urandom);
    end
    valid = 1'b0;
    check("event_seen", exp_q.size(), 0);
    check("final_detected", echo_detected, e.is_echo);
    check("final_state", state, e.is_echo ? StDetected : StTimeout);
    smp_val.delete();
  endtask

  initial begin
    int unsigned thr;
    repeat (3) @(posedge clk_100mhz);
    @(negedge clk_100mhz);
    check("reset_state", state, StIdle);
    check("reset_flags", {echo_detected, echo_pulse, no_echo}, 0);
    check("reset_baseline", baseline, 0);
    check("reset_time", echo_time, 0);
    rst = 1'b0;

    load_blank(); smp_val[200] = 560; smp_val[300] = 570; smp_val[400] = 580;
    run_episode(50, 0, 0);
    load_blank(); smp_val[200] = 560; smp_val[250] = 510; smp_val[300] = 560;
    smp_val[350] = 570; smp_val[400] = 580;
    run_episode(50, 1, 0);
    load_blank(); smp_val[200] = 550; smp_val[210] = 450; smp_val[220] = 550;
    smp_val[230] = 550;
    run_episode(50, 1, 0);
    load_blank(); smp_val[WC-2] = 560; smp_val[WC-1] = 570; smp_val[WC] = 580;
    run_episode(50, 1, 0);
    load_blank(); smp_val[200] = 560; smp_val[210] = 570;
    run_episode(50, 1, 215);

    for (int i = 0; i < 12; i++) begin
      gen_random(thr);
      run_episode(thr, 1'($urandom_range(0, 1)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
